ub_stream_controller: RTL and testbench
=======================================

Name: ub_stream_controller

Overview:
Sequences one tile transfer through the unified buffer and the input/weight streaming skewers ahead of the systolic array. On a start pulse it issues K consecutive read addresses on both UB read ports, with first/last framing. It gates the skewer enable and holds it through the pipeline drain. It then reports completion, so a top-level scheduler can launch tiles back-to-back.

Parameters:
N, `ARRAY_SIZE, array dimension; sets skewer depth.
ADDR_WIDTH, `ADDR_WIDTH, UB address width.
LEN_WIDTH, 16, width of the tile length K.
UB_LAT, 1, UB read latency in cycles (address to data/first/last out).

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-low
start  in  1  launch pulse; sampled only in IDLE
input_base  in  ADDR_WIDTH  first input-row address; latched on accepted start
weight_base  in  ADDR_WIDTH  first weight-row address; latched on accepted start
len  in  LEN_WIDTH  K, rows to stream; latched on accepted start
hold  in  1  stall request; freezes sequencing while high
abort  in  1  cancel the current tile
busy  out  1  high in STREAM and DRAIN
done  out  1  one-cycle pulse at tile end (normal, K=0, or abort)
input_addr  out  ADDR_WIDTH  UB input read address
input_first_in  out  1  framing to UB input port
input_last_in  out  1  framing to UB input port
weight_addr  out  ADDR_WIDTH  UB weight read address
weight_first_in  out  1  framing to UB weight port
weight_last_in  out  1  framing to UB weight port
skew_en  out  1  enable to both skewers

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; counters 0. Reset mid-tile discards the tile with no done pulse.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE -> STREAM on start with len>0. Latch bases and len; row counter i=0.
- IDLE -> DONE on start with len==0. No addresses and no framing are issued.
- STREAM: each non-held cycle drives input_addr=in_base+i and weight_addr=wt_base+i, registered.
  - Address sums wrap modulo 2^ADDR_WIDTH.
  - first_in=1 iff i==0; last_in=1 iff i==K-1. Both are 1 together when K=1.
  - i increments each non-held cycle. After the i==K-1 cycle, go to DRAIN with drain counter d=0.
- DRAIN lasts D=UB_LAT+N cycles (non-held); d increments each non-held cycle. Framing outputs are 0; addresses hold their last value. After d==D-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE; it is accepted on the following cycle in IDLE.
- Outputs are registered. The first address appears on the cycle after start is accepted. The total cycles from start to done are K+D+1 when there is no hold.
- skew_en=1 in STREAM and DRAIN while hold=0; 0 otherwise.
- hold=1 in STREAM or DRAIN:
  - i and d freeze.
  - addresses and framing hold their values, but first_in/last_in are forced to 0 to prevent duplicate framing.
  - skew_en=0.
  - The UB re-reads the same address harmlessly, because its data is gated by skew_en.
- hold in IDLE or DONE has no effect.
- abort in STREAM or DRAIN (priority over hold) -> DONE next cycle. Framing is forced to 0 and skew_en=0 that cycle. abort in IDLE is ignored.
- start while busy is ignored, with no queueing.
- busy=1 exactly when state is STREAM or DRAIN.

Decomposition:
- Shared package `npu_ctrl_pkg`:
  - state enum ub_ctrl_state_t {IDLE, STREAM, DRAIN, DONE}
  - localparam computing drain depth from UB_LAT and N
- Sub-module `tile_counter`: load/enable/terminal-count counter, instantiated twice for the row counter and the drain counter.
- Address adders and framing logic stay inline.

Test Plan:
- N=4, UB_LAT=1, start with input_base=0x10, weight_base=0x40, len=3 -> input_addr 0x10,0x11,0x12 and weight_addr 0x40,0x41,0x42 on cycles 1-3. first_in only on cycle 1, last_in only on cycle 3. skew_en high cycles 1-8. done on cycle 9. busy is 1 on cycles 1-8.
- len=1 -> first_in and last_in both 1 on cycle 1; done on cycle 7.
- len=0 -> done on cycle 1; no addresses, no framing, busy and skew_en stay 0.
- len=4, hold high for 2 cycles after the second address -> addresses repeat 0x11 with framing 0 and skew_en 0. The sequence resumes at 0x12, and done is delayed by exactly 2 cycles.
- input_base=2^ADDR_WIDTH-2, len=3 -> addresses wrap: max-1, max, 0.
- abort during cycle 2 of STREAM -> done pulses on the next cycle, skew_en drops to 0, and state returns to IDLE. A start asserted during busy is ignored. rst_n low mid-DRAIN clears all outputs on the next edge with no done pulse.

Source files
------------

// File: rtl/npu_ctrl_pkg.sv
// Shared types and helpers for the NPU streaming controllers.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package npu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } ub_ctrl_state_t;

    localparam int DEFAULT_UB_LAT      = 1;
    localparam int DEFAULT_DRAIN_DEPTH = DEFAULT_UB_LAT + `ARRAY_SIZE;

    // Cycles the skewers must keep running after the last row address:
    // UB read latency plus the full skew depth of the array.
    function automatic int drain_depth(input int ub_lat, input int n);
        return ub_lat + n;
    endfunction

    // Counter width able to hold 0 .. depth-1 (at least one bit).
    function automatic int drain_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ub_stream_controller_tile_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
module tile_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    // Count register: clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/ub_stream_controller.sv
// Streams one tile of K rows from the unified buffer into the skewers,
// then drains the pipeline and pulses done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; start with len==0 goes straight to DONE
// STREAM | issuing row i on both UB read ports, i = 0 .. K-1
// DRAIN  | skewers kept running for UB_LAT+N cycles, no framing
// DONE   | one-cycle done pulse, start ignored
module ub_stream_controller
    import npu_ctrl_pkg::*;
#(
    parameter int N          = `ARRAY_SIZE,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int LEN_WIDTH  = 16,
    parameter int UB_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] input_base,
    input  logic [ADDR_WIDTH-1:0] weight_base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  hold,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] input_addr,
    output logic                  input_first_in,
    output logic                  input_last_in,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic                  weight_first_in,
    output logic                  weight_last_in,
    output logic                  skew_en
);

    localparam int D  = drain_depth(UB_LAT, N);
    localparam int DW = drain_width(D);
    localparam logic [DW-1:0] D_TERM = DW'(D - 1);

    ub_ctrl_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] in_base_q, wt_base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  latch_tile;

    logic [LEN_WIDTH-1:0]  row_count, row_next, row_term;
    logic                  row_tc, row_clear, row_en;
    logic [DW-1:0]         drain_count;
    logic                  drain_tc, drain_clear, drain_en;

    logic [ADDR_WIDTH-1:0] in_addr_nxt, wt_addr_nxt;
    logic                  first_nxt, last_nxt, skew_nxt;

    // Row counter i indexes the row currently on the UB ports.
    assign row_term  = len_q - LEN_WIDTH'(1);
    assign row_clear = (state == IDLE);

    tile_counter #(.WIDTH(LEN_WIDTH)) u_row_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (row_clear),
        .enable  (row_en),
        .term    (row_term),
        .count   (row_count),
        .at_term (row_tc)
    );

    // Drain counter sits at zero until DRAIN is entered.
    assign drain_clear = (state != DRAIN);

    tile_counter #(.WIDTH(DW)) u_drain_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (drain_clear),
        .enable  (drain_en),
        .term    (D_TERM),
        .count   (drain_count),
        .at_term (drain_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter controls and next registered output values.
    // Abort outranks hold; a held cycle re-presents the same address with
    // framing cleared so the UB never sees a row framed twice.
    always_comb begin
        state_nxt   = state;
        latch_tile  = 1'b0;
        row_en      = 1'b0;
        drain_en    = 1'b0;
        in_addr_nxt = input_addr;
        wt_addr_nxt = weight_addr;
        first_nxt   = 1'b0;
        last_nxt    = 1'b0;
        skew_nxt    = 1'b0;
        row_next    = row_count + LEN_WIDTH'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    latch_tile = 1'b1;
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = STREAM;
                        in_addr_nxt = input_base;
                        wt_addr_nxt = weight_base;
                        first_nxt   = 1'b1;
                        last_nxt    = (len == LEN_WIDTH'(1));
                        skew_nxt    = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (!hold) begin
                    skew_nxt = 1'b1;
                    if (row_tc) begin
                        state_nxt = DRAIN;
                    end else begin
                        row_en      = 1'b1;
                        in_addr_nxt = in_base_q + ADDR_WIDTH'(row_next);
                        wt_addr_nxt = wt_base_q + ADDR_WIDTH'(row_next);
                        last_nxt    = (row_next == row_term);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (!hold) begin
                    if (drain_tc) begin
                        state_nxt = DONE;
                    end else begin
                        drain_en = 1'b1;
                        skew_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tile parameters captured on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_base_q <= '0;
            wt_base_q <= '0;
            len_q     <= '0;
        end else if (latch_tile) begin
            in_base_q <= input_base;
            wt_base_q <= weight_base;
            len_q     <= len;
        end
    end

    // Registered UB port and skewer outputs; both ports share framing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            input_addr      <= '0;
            weight_addr     <= '0;
            input_first_in  <= 1'b0;
            input_last_in   <= 1'b0;
            weight_first_in <= 1'b0;
            weight_last_in  <= 1'b0;
            skew_en         <= 1'b0;
        end else begin
            input_addr      <= in_addr_nxt;
            weight_addr     <= wt_addr_nxt;
            input_first_in  <= first_nxt;
            input_last_in   <= last_nxt;
            weight_first_in <= first_nxt;
            weight_last_in  <= last_nxt;
            skew_en         <= skew_nxt;
        end
    end

    assign busy = (state == STREAM) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ub_stream_controller.sv
// Self-checking bench for ub_stream_controller (N=4, UB_LAT=1, 8-bit addresses).
module tb_ub_stream_controller;

    localparam int AW     = 8;
    localparam int LW     = 16;
    localparam int N      = 4;
    localparam int UB_LAT = 1;
    localparam int D      = UB_LAT + N;

    logic          clk = 1'b0;
    logic          rst_n, start, hold, abort;
    logic [AW-1:0] input_base, weight_base;
    logic [LW-1:0] len;
    logic          busy, done, skew_en;
    logic [AW-1:0] input_addr, weight_addr;
    logic          input_first_in, input_last_in, weight_first_in, weight_last_in;

    ub_stream_controller #(
        .N(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .UB_LAT(UB_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input_base(input_base), .weight_base(weight_base), .len(len),
        .hold(hold), .abort(abort),
        .busy(busy), .done(done),
        .input_addr(input_addr), .input_first_in(input_first_in), .input_last_in(input_last_in),
        .weight_addr(weight_addr), .weight_first_in(weight_first_in), .weight_last_in(weight_last_in),
        .skew_en(skew_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [AW-1:0] ia;
        logic          ifi;
        logic          ila;
        logic [AW-1:0] wa;
        logic          wfi;
        logic          wla;
        logic          skew;
    } obs_t;

    // hs/hn: first edge hold is seen and how many edges; ab: edge abort is
    // seen; sb: edge a stray start is seen; exp_done: cycle of done pulse.
    typedef struct {
        logic [AW-1:0] ib;
        logic [AW-1:0] wb;
        logic [LW-1:0] ln;
        int            hs;
        int            hn;
        int            ab;
        int            sb;
        int            exp_done;
        string         name;
    } vec_t;

    obs_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] m_ia = '0;
    logic [AW-1:0] m_wa = '0;
    vec_t          vecs[10];

    function automatic obs_t sample();
        return {busy, done, input_addr, input_first_in, input_last_in,
                weight_addr, weight_first_in, weight_last_in, skew_en};
    endfunction

    function automatic obs_t mk(logic b, logic d, logic [AW-1:0] ia, logic f, logic l,
                                logic [AW-1:0] wa, logic s);
        return {b, d, ia, f, l, wa, f, l, s};
    endfunction

    task automatic check_obs(string name, int cyc, obs_t exp);
        obs_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h (busy,done,ia,if,il,wa,wf,wl,skew)",
                     name, cyc, act, exp);
        end
    endtask

    // Cycle-by-cycle reference of the UB port/skewer outputs for one tile.
    task automatic build_model(vec_t v);
        int   row, dr, ph, k;
        logic hld, abt;
        int   ln;
        ln = int'(v.ln);
        if (ln == 0) begin
            exp_q.push_back(mk(1'b0, 1'b1, m_ia, 1'b0, 1'b0, m_wa, 1'b0));
        end else begin
            m_ia = v.ib;
            m_wa = v.wb;
            row  = 0;
            dr   = 0;
            ph   = 0;
            exp_q.push_back(mk(1'b1, 1'b0, m_ia, 1'b1, ln == 1, m_wa, 1'b1));
            for (k = 2; k < 1000; k++) begin
                hld = (v.hs != 0) && (k >= v.hs) && (k < v.hs + v.hn);
                abt = (k == v.ab);
                if (abt) begin
                    exp_q.push_back(mk(1'b0, 1'b1, m_ia, 1'b0, 1'b0, m_wa, 1'b0));
                    break;
                end else if (hld) begin
                    exp_q.push_back(mk(1'b1, 1'b0, m_ia, 1'b0, 1'b0, m_wa, 1'b0));
                end else if (ph == 0 && row < ln - 1) begin
                    row++;
                    m_ia = v.ib + AW'(row);
                    m_wa = v.wb + AW'(row);
                    exp_q.push_back(mk(1'b1, 1'b0, m_ia, 1'b0, row == ln - 1, m_wa, 1'b1));
                end else if (ph == 0) begin
                    ph = 1;
                    dr = 0;
                    exp_q.push_back(mk(1'b1, 1'b0, m_ia, 1'b0, 1'b0, m_wa, 1'b1));
                end else if (dr < D - 1) begin
                    dr++;
                    exp_q.push_back(mk(1'b1, 1'b0, m_ia, 1'b0, 1'b0, m_wa, 1'b1));
                end else begin
                    exp_q.push_back(mk(1'b0, 1'b1, m_ia, 1'b0, 1'b0, m_wa, 1'b0));
                    break;
                end
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, m_ia, 1'b0, 1'b0, m_wa, 1'b0));
    endtask

    task automatic run_vec(vec_t v);
        int   k, done_at;
        obs_t e;
        build_model(v);
        input_base  = v.ib;
        weight_base = v.wb;
        len         = v.ln;
        start       = 1'b1;
        hold        = 1'b0;
        abort       = 1'b0;
        done_at     = 0;
        k           = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            k++;
            e = exp_q.pop_front();
            if (done === 1'b1 && done_at == 0) done_at = k;
            check_obs(v.name, k, e);
            // Any later start carries different parameters so acceptance would show.
            input_base  = v.ib ^ 8'h5A;
            weight_base = v.wb ^ 8'hA5;
            len         = 16'd2;
            start       = (k + 1 == v.sb);
            hold        = (v.hs != 0) && (k + 1 >= v.hs) && (k + 1 < v.hs + v.hn);
            abort       = (k + 1 == v.ab);
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (done_at != v.exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d expected %0d", v.name, done_at, v.exp_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h10, 8'h40, 16'd3, 0, 0, 0, 0, 9,  "basic_k3"};
        vecs[1] = '{8'h20, 8'h50, 16'd1, 0, 0, 0, 0, 7,  "single_k1"};
        vecs[2] = '{8'h33, 8'h44, 16'd0, 0, 0, 0, 0, 1,  "empty_k0"};
        vecs[3] = '{8'h10, 8'h40, 16'd4, 3, 2, 0, 0, 12, "hold_stream"};
        vecs[4] = '{8'hFE, 8'h7F, 16'd3, 0, 0, 0, 0, 9,  "addr_wrap"};
        vecs[5] = '{8'h10, 8'h40, 16'd5, 0, 0, 3, 0, 3,  "abort_stream"};
        vecs[6] = '{8'h30, 8'h60, 16'd3, 0, 0, 0, 4, 9,  "start_while_busy"};
        vecs[7] = '{8'h70, 8'h80, 16'd2, 5, 3, 0, 0, 11, "hold_drain"};
        vecs[8] = '{8'h11, 8'h22, 16'd2, 4, 2, 5, 0, 5,  "abort_over_hold"};
        vecs[9] = '{8'h05, 8'h06, 16'd2, 0, 0, 0, 9, 8,  "start_in_done"};

        rst_n       = 1'b0;
        start       = 1'b0;
        hold        = 1'b0;
        abort       = 1'b0;
        input_base  = '0;
        weight_base = '0;
        len         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_state", 0, '0);
        rst_n = 1'b1;

        // hold and abort in IDLE do nothing
        hold  = 1'b1;
        abort = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check_obs("idle_hold_abort", c, '0);
        end
        hold  = 1'b0;
        abort = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // reset in the middle of DRAIN: cleared outputs, no done pulse
        input_base  = 8'h20;
        weight_base = 8'h60;
        len         = 16'd3;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_obs("pre_reset_drain", 5, mk(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h62, 1'b1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_obs("reset_mid_drain", 6, '0);
        rst_n = 1'b1;
        for (int c = 7; c <= 14; c++) begin
            @(posedge clk);
            #1;
            check_obs("after_reset_quiet", c, '0);
        end
        m_ia = '0;
        m_wa = '0;

        // controller accepts a fresh tile after the reset
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
